// File: rtl/operand_memory_ctrl.sv
// Operand/result memory for the FIOS Montgomery multiplier: loads n, n_prime_0, X and Y from BRAM and stores results.
// Optional build macro OPMEM_SCRUB_ON_STORE_EN: scrub operand registers and the n_prime_0 BRAM word after a store.
module operand_memory_ctrl #(
  parameter int S      = 16,
  parameter int W      = 17,
  parameter int BRAM_W = 32,
  parameter int RD_LAT = 2,
  parameter int PE_NB  = (2*S+5)/9+1,
  parameter int AW     = $clog2(3*S+1)
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic                load_store_i,
  input  logic [BRAM_W-1:0]   BRAM_dout_i,
  input  logic [W-1:0]        res_i,
  input  logic                res_push_i,
  input  logic                Y_fetch_i,
  input  logic                n_fetch_i,
  input  logic                shift_X_i,
  output logic                BRAM_en_o,
  output logic                BRAM_we_o,
  output logic [AW-1:0]       BRAM_addr_o,
  output logic [BRAM_W-1:0]   BRAM_din_o,
  output logic [PE_NB*W-1:0]  X_o,
  output logic [W-1:0]        Y_o,
  output logic [W-1:0]        n_o,
  output logic [W-1:0]        n_prime_0_o,
  output logic                busy_o,
  output logic                load_done_o,
  output logic                store_done_o,
  output logic                error_o
);

  localparam int RAW_CW = $clog2(RD_LAT + 1);
  localparam int CW     = (AW > RAW_CW) ? AW : RAW_CW;

  localparam logic [CW-1:0] LAST_ISSUE = CW'(3*S);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] NP0_ADDR   = CW'(S);
  localparam logic [CW-1:0] X_LAST     = CW'(2*S);
`ifdef OPMEM_SCRUB_ON_STORE_EN
  localparam logic [CW-1:0] STORE_LAST = CW'(S);
`else
  localparam logic [CW-1:0] STORE_LAST = CW'(S - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ISSUE,
    LOAD_DRAIN,
    STORE,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    TAG_N,
    TAG_NP0,
    TAG_X,
    TAG_Y
  } tag_e;

  state_e          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            op_reg, op_next;

  logic [S*W-1:0]  n_reg;
  logic [S*W-1:0]  x_reg;
  logic [S*W-1:0]  y_reg;
  logic [S*W-1:0]  res_reg;
  logic [W-1:0]    np0_reg;
  logic            error_reg;

  logic [RD_LAT-1:0] vld_pipe;
  tag_e              tag_pipe [RD_LAT];
  tag_e              rd_tag;
  logic              rd_issue;
  logic              cap_vld;
  tag_e              cap_tag;
  logic [W-1:0]      cap_data;

  logic            busy;
  logic            store_last;
  logic            protocol_err;

  // Only the low W bits of a BRAM word carry operand data.
  generate
    if (BRAM_W > W) begin : g_dout_hi
      logic unused_dout_hi;
      assign unused_dout_hi = ^BRAM_dout_i[BRAM_W-1:W];
    end
  endgenerate

  assign busy         = (state_reg != IDLE);
  assign rd_issue     = (state_reg == LOAD_ISSUE);
  assign store_last   = (state_reg == STORE) && (cnt_reg == STORE_LAST);
  assign cap_vld      = vld_pipe[RD_LAT-1];
  assign cap_tag      = tag_pipe[RD_LAT-1];
  assign cap_data     = BRAM_dout_i[W-1:0];
  assign protocol_err = busy && (start_i || Y_fetch_i || n_fetch_i || shift_X_i || res_push_i);

  // Destination of the address currently being issued, from the memory map.
  always_comb begin
    rd_tag = TAG_Y;
    if (cnt_reg < NP0_ADDR) begin
      rd_tag = TAG_N;
    end else if (cnt_reg == NP0_ADDR) begin
      rd_tag = TAG_NP0;
    end else if (cnt_reg <= X_LAST) begin
      rd_tag = TAG_X;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    BRAM_en_o    = 1'b0;
    BRAM_we_o    = 1'b0;
    BRAM_addr_o  = '0;
    BRAM_din_o   = '0;
    load_done_o  = 1'b0;
    store_done_o = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start_i) begin
          op_next    = load_store_i;
          state_next = load_store_i ? STORE : LOAD_ISSUE;
        end
      end
      LOAD_ISSUE: begin
        BRAM_en_o   = 1'b1;
        BRAM_addr_o = AW'(cnt_reg);
        if (cnt_reg == LAST_ISSUE) begin
          cnt_next   = '0;
          state_next = LOAD_DRAIN;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      LOAD_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STORE: begin
        BRAM_en_o   = 1'b1;
        BRAM_we_o   = 1'b1;
        BRAM_addr_o = AW'(cnt_reg);
        BRAM_din_o  = BRAM_W'(res_reg[W-1:0]);
`ifdef OPMEM_SCRUB_ON_STORE_EN
        if (cnt_reg == NP0_ADDR) begin
          BRAM_din_o = '0;
        end
`endif
        if (cnt_reg == STORE_LAST) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        load_done_o  = ~op_reg;
        store_done_o = op_reg;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tag pipeline matches BRAM read latency so each word lands in the right register.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_pipe[i] <= TAG_N;
      end
    end else begin
      vld_pipe[0] <= rd_issue;
      tag_pipe[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      n_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      res_reg   <= '0;
      np0_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      if (cap_vld) begin
        case (cap_tag)
          TAG_N:   n_reg   <= {cap_data, n_reg[S*W-1:W]};
          TAG_NP0: np0_reg <= cap_data;
          TAG_X:   x_reg   <= {cap_data, x_reg[S*W-1:W]};
          default: y_reg   <= {cap_data, y_reg[S*W-1:W]};
        endcase
      end

      if (!busy) begin
        if (Y_fetch_i) begin
          y_reg <= y_reg >> W;
        end
        if (n_fetch_i) begin
          n_reg <= n_reg >> W;
        end
        if (shift_X_i) begin
          x_reg <= x_reg >> (PE_NB*W);
        end
        if (res_push_i) begin
          res_reg <= {res_i, res_reg[S*W-1:W]};
        end
      end else if (state_reg == STORE) begin
        res_reg <= res_reg >> W;
      end

`ifdef OPMEM_SCRUB_ON_STORE_EN
      if (store_last) begin
        n_reg   <= '0;
        x_reg   <= '0;
        y_reg   <= '0;
        np0_reg <= '0;
      end
`endif

      if (protocol_err) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign X_o         = x_reg[PE_NB*W-1:0];
  assign Y_o         = y_reg[W-1:0];
  assign n_o         = n_reg[W-1:0];
  assign n_prime_0_o = np0_reg;
  assign busy_o      = busy;
  assign error_o     = error_reg;

endmodule

// File: tb/tb_operand_memory_ctrl.sv
// Self-checking bench for operand_memory_ctrl (S=4, W=17, RD_LAT=2) with a BRAM model and access scoreboard.
module tb_operand_memory_ctrl;

  localparam int S      = 4;
  localparam int W      = 17;
  localparam int BRAM_W = 32;
  localparam int RD_LAT = 2;
  localparam int PE_NB  = (2*S+5)/9+1;
  localparam int AW     = $clog2(3*S+1);
`ifdef OPMEM_SCRUB_ON_STORE_EN
  localparam int STORE_WR = S + 1;
`else
  localparam int STORE_WR = S;
`endif

  typedef struct packed {
    logic              we;
    logic [AW-1:0]     addr;
    logic [BRAM_W-1:0] din;
  } bram_txn_t;

  logic                clk = 1'b0;
  logic                reset_ni;
  logic                start_i;
  logic                load_store_i;
  logic [BRAM_W-1:0]   BRAM_dout_i;
  logic [W-1:0]        res_i;
  logic                res_push_i;
  logic                Y_fetch_i;
  logic                n_fetch_i;
  logic                shift_X_i;
  logic                BRAM_en_o;
  logic                BRAM_we_o;
  logic [AW-1:0]       BRAM_addr_o;
  logic [BRAM_W-1:0]   BRAM_din_o;
  logic [PE_NB*W-1:0]  X_o;
  logic [W-1:0]        Y_o;
  logic [W-1:0]        n_o;
  logic [W-1:0]        n_prime_0_o;
  logic                busy_o;
  logic                load_done_o;
  logic                store_done_o;
  logic                error_o;

  int n_vec = 0;
  int n_err = 0;
  bram_txn_t exp_q [$];

  logic [BRAM_W-1:0] mem [16];
  logic [BRAM_W-1:0] rd_d1, rd_d2;

  operand_memory_ctrl #(
    .S(S), .W(W), .BRAM_W(BRAM_W), .RD_LAT(RD_LAT)
  ) dut (
    .clock_i(clk),
    .reset_ni(reset_ni),
    .start_i(start_i),
    .load_store_i(load_store_i),
    .BRAM_dout_i(BRAM_dout_i),
    .res_i(res_i),
    .res_push_i(res_push_i),
    .Y_fetch_i(Y_fetch_i),
    .n_fetch_i(n_fetch_i),
    .shift_X_i(shift_X_i),
    .BRAM_en_o(BRAM_en_o),
    .BRAM_we_o(BRAM_we_o),
    .BRAM_addr_o(BRAM_addr_o),
    .BRAM_din_o(BRAM_din_o),
    .X_o(X_o),
    .Y_o(Y_o),
    .n_o(n_o),
    .n_prime_0_o(n_prime_0_o),
    .busy_o(busy_o),
    .load_done_o(load_done_o),
    .store_done_o(store_done_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  // BRAM model: data for an address issued in cycle t is on dout in cycle t+2.
  always @(posedge clk) begin
    if (BRAM_en_o && BRAM_we_o) mem[BRAM_addr_o] <= BRAM_din_o;
    rd_d1 <= mem[BRAM_addr_o];
    rd_d2 <= rd_d1;
  end
  assign BRAM_dout_i = rd_d2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every BRAM access is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (reset_ni) begin
      if (BRAM_en_o) begin
        if (exp_q.size() == 0) begin
          chk("bram_unexpected_access", {BRAM_we_o, 28'(BRAM_addr_o)}, 0);
        end else begin
          bram_txn_t e;
          e = exp_q.pop_front();
          $display("bram %s addr=%0d din=0x%0h", BRAM_we_o ? "wr" : "rd", BRAM_addr_o, BRAM_din_o);
          chk("bram_we", BRAM_we_o, e.we);
          chk("bram_addr", BRAM_addr_o, e.addr);
          if (e.we) chk("bram_din", BRAM_din_o, e.din);
        end
      end else begin
        chk("bram_addr_idle", BRAM_addr_o, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int inject_at, output int lat);
    for (int a = 0; a < 3*S+1; a++) exp_q.push_back('{we: 1'b0, addr: AW'(a), din: '0});
    start_i = 1'b1;
    load_store_i = 1'b0;
    tick();
    start_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == inject_at) begin
        start_i = 1'b1;
        load_store_i = 1'b1;
        Y_fetch_i = 1'b1;
      end
      tick();
      start_i = 1'b0;
      load_store_i = 1'b0;
      Y_fetch_i = 1'b0;
      if (load_done_o) begin
        lat = c;
        break;
      end
    end
    $display("load complete after %0d cycles", lat);
  endtask

  task automatic check_operands(input string tag, input logic [PE_NB*W-1:0] x,
                                input logic [W-1:0] y, input logic [W-1:0] n, input logic [W-1:0] np0);
    chk({tag, "_X"}, X_o, x);
    chk({tag, "_Y"}, Y_o, y);
    chk({tag, "_n"}, n_o, n);
    chk({tag, "_np0"}, n_prime_0_o, np0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] y_exp [4];
    logic [W-1:0] res_vals [4];
    y_exp = '{17'd11, 17'd12, 17'd13, 17'd0};
    res_vals = '{17'h1_0001, 17'd2, 17'd3, 17'd4};

    for (int a = 0; a < 16; a++) mem[a] = {15'h5A5A, 17'(a + 1)};
    reset_ni = 1'b0;
    start_i = 1'b0;
    load_store_i = 1'b0;
    res_i = '0;
    res_push_i = 1'b0;
    Y_fetch_i = 1'b0;
    n_fetch_i = 1'b0;
    shift_X_i = 1'b0;
    repeat (3) tick();
    reset_ni = 1'b1;

    chk("rst_busy", busy_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_en", BRAM_en_o, 0);
    check_operands("rst", '0, '0, '0, '0);

    // Plain load and latency
    run_load(0, lat);
    chk("load_done_lat", lat, 15);
    chk("load_busy_in_done", busy_o, 1);
    check_operands("load", {17'd7, 17'd6}, 17'd10, 17'd1, 17'd5);
    tick();
    chk("load_done_width", load_done_o, 0);
    chk("load_busy_fall", busy_o, 0);
    chk("load_q_empty", exp_q.size(), 0);

    // Y fetches down to empty
    for (int i = 0; i < 4; i++) begin
      Y_fetch_i = 1'b1;
      tick();
      Y_fetch_i = 1'b0;
      $display("Y fetch %0d -> Y_o=0x%0h", i, Y_o);
      chk("y_fetch", Y_o, y_exp[i]);
    end
    chk("y_fetch_n_kept", n_o, 17'd1);
    chk("y_fetch_error", error_o, 0);

    // n fetch, then X shifts past the end
    n_fetch_i = 1'b1;
    tick();
    n_fetch_i = 1'b0;
    chk("n_fetch", n_o, 17'd2);
    shift_X_i = 1'b1;
    tick();
    chk("x_shift1", X_o, {17'd9, 17'd8});
    tick();
    shift_X_i = 1'b0;
    chk("x_shift2", X_o, '0);
    chk("x_shift_error", error_o, 0);

    // Reload with a stray start and Y fetch mid-load
    run_load(3, lat);
    chk("err_load_lat", lat, 15);
    check_operands("err_load", {17'd7, 17'd6}, 17'd10, 17'd1, 17'd5);
    chk("err_flag", error_o, 1);
    repeat (3) tick();
    chk("err_sticky", error_o, 1);
    chk("err_q_empty", exp_q.size(), 0);

    // Push results then store them
    for (int i = 0; i < 4; i++) begin
      res_i = res_vals[i];
      res_push_i = 1'b1;
      tick();
    end
    res_push_i = 1'b0;
    res_i = '0;
    for (int i = 0; i < S; i++) exp_q.push_back('{we: 1'b1, addr: AW'(i), din: BRAM_W'(res_vals[i])});
`ifdef OPMEM_SCRUB_ON_STORE_EN
    exp_q.push_back('{we: 1'b1, addr: AW'(S), din: '0});
`endif
    start_i = 1'b1;
    load_store_i = 1'b1;
    tick();
    start_i = 1'b0;
    load_store_i = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (store_done_o) begin
        lat = c;
        break;
      end
    end
    $display("store complete after %0d cycles", lat);
    chk("store_done_lat", lat, STORE_WR);
`ifdef OPMEM_SCRUB_ON_STORE_EN
    check_operands("scrub", '0, '0, '0, '0);
`else
    check_operands("store_keep", {17'd7, 17'd6}, 17'd10, 17'd1, 17'd5);
`endif
    tick();
    chk("store_done_width", store_done_o, 0);
    chk("store_busy_fall", busy_o, 0);
    chk("store_q_empty", exp_q.size(), 0);
    chk("store_mem0", mem[0], 32'h0001_0001);
    chk("store_mem3", mem[3], 32'd4);

    // Reset in the middle of a load
    for (int a = 0; a < 3*S+1; a++) exp_q.push_back('{we: 1'b0, addr: AW'(a), din: '0});
    start_i = 1'b1;
    load_store_i = 1'b0;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    reset_ni = 1'b0;
    tick();
    exp_q.delete();
    $display("reset applied mid-load");
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_en", BRAM_en_o, 0);
    chk("mid_rst_addr", BRAM_addr_o, 0);
    chk("mid_rst_error", error_o, 0);
    chk("mid_rst_done", {load_done_o, store_done_o}, 0);
    check_operands("mid_rst", '0, '0, '0, '0);
    reset_ni = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (load_done_o) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    chk("mid_rst_idle", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/operand_memory_ctrl.md
Name: operand_memory_ctrl

Overview:
- Next-generation operand/result memory for the FIOS Montgomery multiplier, with an integrated load/store FSM.
- Loads n, n_prime_0, X and Y from a single-port BRAM into shift registers and feeds them to the PE chain.
- Collects result blocks and writes them back to BRAM.
- Generalises block width, block count, BRAM word width and read latency, and adds busy/error handshaking.

Parameters:
- S, 16: number of operand blocks per operand.
- W, 17: block width in bits.
- BRAM_W, 32: BRAM data width; must satisfy BRAM_W >= W.
- RD_LAT, 2: cycles from BRAM_addr_o issue to BRAM_dout_i capture; minimum 1.
- PE_NB, (2*S+5)/9+1: X blocks exposed to the PEs at once.
- AW, $clog2(3*S+1): BRAM address width.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_ni  in  1  reset; synchronous, active-low.
- start_i  in  1  starts an operation; sampled only in IDLE.
- load_store_i  in  1  0 = load operands, 1 = store result; sampled with start_i.
- BRAM_dout_i  in  BRAM_W  BRAM read data; bits [W-1:0] are used.
- res_i  in  W  result block.
- res_push_i  in  1  capture res_i into the result register.
- Y_fetch_i  in  1  advance Y by one block.
- n_fetch_i  in  1  advance n by one block.
- shift_X_i  in  1  advance X by PE_NB blocks.
- BRAM_en_o  out  1  BRAM port enable.
- BRAM_we_o  out  1  BRAM write enable.
- BRAM_addr_o  out  AW  BRAM address.
- BRAM_din_o  out  BRAM_W  write data: result block zero-extended to BRAM_W.
- X_o  out  PE_NB*W  lowest PE_NB blocks of X.
- Y_o  out  W  lowest block of Y.
- n_o  out  W  lowest block of n.
- n_prime_0_o  out  W  n_prime_0 value.
- busy_o  out  1  high in every non-IDLE state.
- load_done_o  out  1  one-cycle pulse when a load completes.
- store_done_o  out  1  one-cycle pulse when a store completes.
- error_o  out  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- BRAM memory map:
  - n at addresses 0..S-1.
  - n_prime_0 at address S.
  - X at S+1..2S.
  - Y at 2S+1..3S.
  - Result is written to 0..S-1.
  - Lowest address holds the least significant block.
- Reset (reset_ni = 0 at a clock edge):
  - All registers and outputs go to 0 and the FSM goes to IDLE.
  - This applies mid-operation as well; in-flight reads are discarded.
- FSM states: IDLE, LOAD_ISSUE, LOAD_DRAIN, STORE, DONE.
- IDLE:
  - start_i=1 with load_store_i=0 -> LOAD_ISSUE.
  - start_i=1 with load_store_i=1 -> STORE.
- LOAD_ISSUE:
  - Runs 3S+1 cycles with BRAM_en_o=1, BRAM_we_o=0, BRAM_addr_o = 0..3S, incrementing by 1 per cycle.
  - After the last address -> LOAD_DRAIN.
- Read capture:
  - Each issued address carries a destination tag (n, n_prime_0, X or Y) down an RD_LAT-deep valid/tag pipeline.
  - On tag arrival, BRAM_dout_i[W-1:0] is inserted as the MS block of the tagged register and the register shifts right by W; n_prime_0 is loaded directly.
- LOAD_DRAIN:
  - Waits RD_LAT cycles with BRAM_en_o=0, then goes to DONE.
  - load_done_o pulses in the cycle after the final capture, so it is visible 3S+1+RD_LAT cycles after the LOAD_ISSUE entry edge.
- STORE:
  - Runs S cycles with BRAM_en_o=1, BRAM_we_o=1, addresses 0..S-1.
  - BRAM_din_o = {0, res_reg[W-1:0]}; res_reg shifts right by W each cycle with zero fill.
  - Then -> DONE, where store_done_o pulses.
- DONE: lasts one cycle, then -> IDLE. busy_o falls on the transition to IDLE.
- Fetch and shift:
  - Y_fetch_i / n_fetch_i shift the register right by W with zero fill.
  - shift_X_i shifts X right by PE_NB*W with zero fill; shifting past empty yields zeros, with no error.
  - All three are honoured only in IDLE. During busy they are ignored and set error_o.
- res_push_i:
  - Honoured in IDLE: res_i becomes the MS block and the register shifts right by W.
  - During STORE it is ignored and sets error_o.
  - More than S pushes silently discards the oldest block.
- Simultaneous events:
  - start_i while busy is ignored and sets error_o.
  - Fetches in the same cycle as start_i in IDLE are honoured, and the FSM transitions.
- BRAM_addr_o is 0 whenever BRAM_en_o=0.

Optional Feature:
- Macro: OPMEM_SCRUB_ON_STORE_EN.
- Defined:
  - On entering DONE from STORE, the X, Y, n and n_prime_0 registers are cleared to 0 in the same cycle store_done_o pulses.
  - One additional BRAM write of 0 to address S (n_prime_0) is issued as the last STORE cycle, so STORE lasts S+1 cycles.
- Undefined: operand registers keep their contents after a store, and STORE lasts exactly S cycles.

Test Plan:
- Load with S=4, W=17, RD_LAT=2, BRAM[a]=a+1 for a=0..12:
  - Addresses 0..12 are issued on consecutive cycles.
  - load_done_o pulses 15 cycles after entry.
  - Afterwards n_o=1, n_prime_0_o=5, Y_o=10, X_o low block=6.
- After load, three Y_fetch_i pulses -> Y_o reads 11, 12, 13; a fourth -> 0; n_o is unchanged; error_o=0.
- Push res_i = 0x1_0001, 2, 3, 4, then store:
  - Writes 0x1_0001, 2, 3, 4 to addresses 0..3 with BRAM_we_o=1 and upper din bits 0.
  - store_done_o pulses 1 cycle after the last write.
- start_i and Y_fetch_i asserted mid-load -> load completes unchanged, error_o=1 and stays 1.
- reset_ni=0 at cycle 5 of LOAD_ISSUE:
  - Next cycle all outputs are 0 and busy_o=0.
  - No load_done_o pulse follows.
- With OPMEM_SCRUB_ON_STORE_EN defined, store after load:
  - X_o, Y_o, n_o and n_prime_0_o read 0 from the store_done_o cycle on.
  - A fifth write of 0 to address 4 is observed.
